pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Drives forwarding selects and per-stage stall/flush enables for the pipeline registers.
- Runs a post-reset boot sequence.
- Freezes the pipeline during data-memory wait states, with a timeout watchdog.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/hazard_fwd_unit.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
//   state_t      : controller state (BOOT, RUN, MEM_WAIT)
//   FWD_*        : operand forwarding select encodings for ForwardAE/ForwardBE
//   RESULT_LOAD  : ResultSrcE encoding that marks a load in Execute
//   fwd_sel()    : forwarding select for one Execute source register
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Memory stage has priority over Writeback because it holds the younger
  // result. x0 is never forwarded since it always reads as zero.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding and load-use detection.
// Ports:
//   rs1_d, rs2_d        : source registers of the instruction in Decode
//   rs1_e, rs2_e        : source registers of the instruction in Execute
//   rd_e, result_src_e  : destination and result select in Execute
//   rd_m, reg_write_m   : destination and write enable in Memory
//   rd_w, reg_write_w   : destination and write enable in Writeback
//   fwd_a, fwd_b        : raw forwarding selects for the two ALU operands
//   load_use            : Decode consumes the result of a load in Execute
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic [1:0] result_src_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       load_use
);

  always_comb begin
    fwd_a = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    fwd_b = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
  end

  // A load into x0 produces nothing to wait for.
  always_comb begin
    load_use = (result_src_e == RESULT_LOAD) && (rd_e != 5'd0) &&
               ((rs1_d == rd_e) || (rs2_d == rd_e));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage (F/D/E/M/W) pipeline.
// Drives forwarding selects and per-stage stall/flush enables, runs a
// post-reset boot sequence, freezes the pipeline on data-memory wait states
// with a timeout watchdog, and keeps saturating stall/flush counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// BOOT     | post-reset warm-up, PC held and all stage registers bubbled
// RUN      | normal operation: forwarding, load-use stall, branch flush
// MEM_WAIT | data memory busy last cycle; whole front end frozen
//
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   Rs1D, Rs2D                  : Decode source registers
//   Rs1E, Rs2E, RdE, ResultSrcE : Execute sources, destination, result select
//   PCSrcE                      : taken branch/jump resolved in Execute
//   RdM, RegWriteM              : Memory destination and write enable
//   DmemReqM, DmemReady         : Memory-stage access request / completion
//   RdW, RegWriteW              : Writeback destination and write enable
//   ForwardAE, ForwardBE        : operand selects (00 RF, 01 WB, 10 MEM)
//   StallF/D/E/M                : hold PC and F/D, D/E, E/M registers
//   FlushD/E/W                  : bubble F/D, D/E, M/W registers
//   MemErr                      : sticky memory-timeout flag
//   StallCount, FlushCount      : saturating performance counters
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES    = 3,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  input  logic [4:0]           RdM,
  input  logic                 RegWriteM,
  input  logic                 DmemReqM,
  input  logic                 DmemReady,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic                 MemErr,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BOOT_LAST   = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] TIMEOUT_VAL = WW'(TIMEOUT_CYCLES);

  state_t         state_q, state_d;
  logic [BW-1:0]  boot_cnt_q, boot_cnt_d;
  logic [WW-1:0]  wait_cnt_q, wait_cnt_d;

  logic [1:0]     fwd_a, fwd_b;
  logic           load_use;
  logic           mem_wait;
  logic           branch_flush;

  hazard_fwd_unit u_hazard_fwd (
    .rs1_d        (Rs1D),
    .rs2_d        (Rs2D),
    .rs1_e        (Rs1E),
    .rs2_e        (Rs2E),
    .rd_e         (RdE),
    .result_src_e (ResultSrcE),
    .rd_m         (RdM),
    .reg_write_m  (RegWriteM),
    .rd_w         (RdW),
    .reg_write_w  (RegWriteW),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .load_use     (load_use)
  );

  always_comb begin
    mem_wait = DmemReqM && !DmemReady;
  end

  // Next state and outputs. Priority outside BOOT:
  // memory wait > branch flush > load-use stall.
  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    ForwardAE    = FWD_RF;
    ForwardBE    = FWD_RF;
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushW       = 1'b0;
    branch_flush = 1'b0;

    case (state_q)
      BOOT: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushW = 1'b1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end

      RUN, MEM_WAIT: begin
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        if (mem_wait) begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          StallM  = 1'b1;
          FlushW  = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          // Leaving MEM_WAIT releases the stalls in this same cycle, so the
          // regular hazard logic already applies here.
          state_d = RUN;
          if (PCSrcE) begin
            // The load-use victim in Decode is squashed anyway, so no stall.
            FlushD       = 1'b1;
            FlushE       = 1'b1;
            branch_flush = 1'b1;
          end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
      end

      default: begin
        StallF  = 1'b1;
        FlushD  = 1'b1;
        FlushE  = 1'b1;
        FlushW  = 1'b1;
        state_d = BOOT;
      end
    endcase
  end

  // The wait counter only runs while the memory is actually holding us off
  // and parks at the timeout value so the flag logic sees a stable compare.
  always_comb begin
    wait_cnt_d = '0;
    if ((state_q != BOOT) && mem_wait) begin
      wait_cnt_d = (wait_cnt_q == TIMEOUT_VAL) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MemErr <= 1'b0;
    end else if (wait_cnt_d == TIMEOUT_VAL) begin
      MemErr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if ((state_q != BOOT) && StallF && (StallCount != '1)) begin
        StallCount <= StallCount + 1'b1;
      end
      if (branch_flush && (FlushCount != '1)) begin
        FlushCount <= FlushCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int BOOT_CYCLES    = 3;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_WIDTH      = 5;

  logic       clk;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, RegWriteM, DmemReqM, DmemReady, RegWriteW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CNT_WIDTH-1:0] StallCount, FlushCount;

  integer checks = 0;
  integer errors = 0;

  pipeline_hazard_ctrl #(
    .BOOT_CYCLES    (BOOT_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .RdM        (RdM),
    .RegWriteM  (RegWriteM),
    .DmemReqM   (DmemReqM),
    .DmemReady  (DmemReady),
    .RdW        (RdW),
    .RegWriteW  (RegWriteW),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .MemErr     (MemErr),
    .StallCount (StallCount),
    .FlushCount (FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
    PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    DmemReqM = 1'b0; DmemReady = 1'b0;
  endtask

  // Release reset with every hazard input asserted; BOOT must ignore them
  // for exactly BOOT_CYCLES cycles, then RUN with all controls low.
  task automatic test_boot_release(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    PCSrcE = 1'b1; DmemReqM = 1'b1; DmemReady = 1'b0;
    ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    for (int c = 1; c <= BOOT_CYCLES; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1000111) begin
        errors++;
        $display("FAIL %s_ctrl cycle %0d got %b want 1000111", tag, c,
                 {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
      end
      checks++;
      if ({ForwardAE, ForwardBE} !== 4'b0000) begin
        errors++;
        $display("FAIL %s_fwd cycle %0d got %b want 0000", tag, c, {ForwardAE, ForwardBE});
      end
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0000000) begin
      errors++;
      $display("FAIL %s_run_ctrl got %b want 0000000", tag,
               {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    end
    checks++;
    if ({MemErr, StallCount, FlushCount} !== {1'b0, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL %s_counts got err=%b stall=%0d flush=%0d want 0 0 0", tag,
               MemErr, StallCount, FlushCount);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #12;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1000111) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1000111",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    end
    checks++;
    if ({ForwardAE, ForwardBE, MemErr, StallCount, FlushCount} !== 15'd0) begin
      errors++;
      $display("FAIL reset_regs got fwd=%b%b err=%b stall=%0d flush=%0d want all 0",
               ForwardAE, ForwardBE, MemErr, StallCount, FlushCount);
    end
    test_boot_release("boot1");
  endtask

  task automatic test_forward();
    @(negedge clk);
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
    Rs1E = 5'd5; Rs2E = 5'd0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b1000) begin
      errors++;
      $display("FAIL fwd_mem_prio got %b want 1000", {ForwardAE, ForwardBE});
    end
    @(negedge clk);
    RegWriteM = 1'b0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0100) begin
      errors++;
      $display("FAIL fwd_wb got %b want 0100", {ForwardAE, ForwardBE});
    end
    @(negedge clk);
    RdW = 5'd0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      errors++;
      $display("FAIL fwd_rdw_zero got %b want 0000", {ForwardAE, ForwardBE});
    end
    @(negedge clk);
    RegWriteM = 1'b1; RdM = 5'd9; RegWriteW = 1'b1; RdW = 5'd4;
    Rs1E = 5'd4; Rs2E = 5'd9;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0110) begin
      errors++;
      $display("FAIL fwd_split got %b want 0110", {ForwardAE, ForwardBE});
    end
    @(negedge clk);
    RdM = 5'd0; Rs1E = 5'd0; RdW = 5'd0; Rs2E = 5'd0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE, StallF} !== 5'b00000) begin
      errors++;
      $display("FAIL fwd_x0 got %b want 00000", {ForwardAE, ForwardBE, StallF});
    end
    idle();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd1; Rs2D = 5'd7;
    #1;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1100010) begin
      errors++;
      $display("FAIL load_use_ctrl got %b want 1100010",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    end
    @(negedge clk);
    RdE = 5'd0; Rs2D = 5'd0;
    #1;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      errors++;
      $display("FAIL load_use_rd0 got %b want 000", {StallF, StallD, FlushE});
    end
    checks++;
    if (StallCount !== 5'd1) begin
      errors++;
      $display("FAIL load_use_count got %0d want 1", StallCount);
    end
    @(negedge clk);
    ResultSrcE = 2'b00; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      errors++;
      $display("FAIL load_use_nonload got %b want 000", {StallF, StallD, FlushE});
    end
    idle();
  endtask

  task automatic test_branch();
    @(negedge clk);
    PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
    #1;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0000110) begin
      errors++;
      $display("FAIL branch_ctrl got %b want 0000110",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({FlushCount, StallCount} !== {5'd1, 5'd1}) begin
      errors++;
      $display("FAIL branch_counts got flush=%0d stall=%0d want 1 1", FlushCount, StallCount);
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      DmemReqM = 1'b1; DmemReady = 1'b0; PCSrcE = (i % 2 == 0);
      ResultSrcE = 2'b01; RdE = 5'd2; Rs1D = 5'd2;
      #1;
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1111001) begin
        errors++;
        $display("FAIL mem_wait_ctrl cycle %0d got %b want 1111001", i,
                 {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
      end
      checks++;
      if (MemErr !== (i >= 17)) begin
        errors++;
        $display("FAIL mem_err cycle %0d got %b want %b", i, MemErr, (i >= 17));
      end
    end
    @(negedge clk);
    idle();
    DmemReqM = 1'b1; DmemReady = 1'b1;
    #1;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr} !== 8'b00000001) begin
      errors++;
      $display("FAIL mem_release got %b want 00000001",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr});
    end
    checks++;
    if ({StallCount, FlushCount} !== {5'd21, 5'd1}) begin
      errors++;
      $display("FAIL mem_counts got stall=%0d flush=%0d want 21 1", StallCount, FlushCount);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({StallF, MemErr} !== 2'b01) begin
      errors++;
      $display("FAIL mem_err_sticky got %b want 01", {StallF, MemErr});
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      DmemReqM = 1'b1; DmemReady = 1'b0;
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({MemErr, StallCount, FlushCount} !== 11'd0) begin
      errors++;
      $display("FAIL async_rst_regs got err=%b stall=%0d flush=%0d want 0 0 0",
               MemErr, StallCount, FlushCount);
    end
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1000111) begin
      errors++;
      $display("FAIL async_rst_ctrl got %b want 1000111",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    end
    @(negedge clk);
    idle();
    test_boot_release("boot2");
  endtask

  // Two 15-cycle waits separated by a release must not trip the watchdog,
  // and the stall counter must stop at all-ones.
  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        DmemReqM = 1'b1; DmemReady = 1'b0;
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if ({MemErr, StallF, StallCount} !== {1'b0, 1'b0, 5'((r + 1) * 15)}) begin
        errors++;
        $display("FAIL b2b_release%0d got err=%b stallf=%b cnt=%0d want 0 0 %0d", r,
                 MemErr, StallF, StallCount, (r + 1) * 15);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      DmemReqM = 1'b1; DmemReady = 1'b0;
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({MemErr, StallCount} !== {1'b0, 5'd31}) begin
      errors++;
      $display("FAIL stall_count_sat got err=%b cnt=%0d want 0 31", MemErr, StallCount);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
